alu_dsp_issue: RTL and testbench
================================

ALU_DSP_ISSUE -- requirements
Module: alu_dsp_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand and result width.
REQ-002 SHALL have parameter REG_W, default 11, meaning register-id width.
REQ-003 SHALL have ports clock (in, 1) and reset_n (in, 1); one clock, reset asynchronous active-low.
REQ-004 SHALL have port in_valid (in, 1): operation offered.
REQ-005 SHALL have port in_ready (out, 1): operation accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_funct (in, 4): op code; 0 AND, 1 OR, 2 XOR, 3 ADD, 4 ADDC, 5 SUB, 6 SEQ, 7 SLTU, 8 SLTS; 9-15 illegal.
REQ-007 SHALL have ports in_rs1, in_rs2 (in, DATA_W each): operand data.
REQ-008 SHALL have ports in_rs1_id, in_rs2_id, in_rd (in, REG_W each): source and destination register ids.
REQ-009 SHALL have port in_carry (in, 1): carry-in operand, used by ADDC only.
REQ-010 SHALL have DSP-side outputs dsp_in0, dsp_in1 (DATA_W), dsp_carryin (1), dsp_opmode (9), dsp_alumode (4), dsp_setinst (2), dsp_valid_in (1).
REQ-011 SHALL have DSP-side inputs dsp_out (DATA_W), dsp_carryout (1), dsp_valid_out (1).
REQ-012 SHALL have writeback outputs wb_valid (1), wb_rd (REG_W), wb_data (DATA_W), wb_carry (1), wb_carry_en (1).
REQ-013 SHALL have sticky outputs illegal_err (1) and proto_err (1).

Function
REQ-014 SHALL decode funct to opmode 000111011 for OR, 000110011 for all other legal ops.
REQ-015 SHALL decode alumode: AND/OR 1100; XOR 0100; ADD/ADDC 0000; SUB/SEQ/SLTU/SLTS 0011.
REQ-016 SHALL decode setinst: SEQ 01, SLTU 10, SLTS 11, all others 00.
REQ-017 SHALL drive dsp_carryin = in_carry for ADDC, 0 otherwise; dsp_in0 = in_rs1, dsp_in1 = in_rs2.
REQ-018 SHALL register all dsp_* outputs: op accepted at edge k yields dsp_valid_in=1 during cycle k+1 only; dsp_* data held at 0 when no op issued.
REQ-019 SHALL carry rd and carry-enable through a 4-slot tag pipeline S0 (issue register), S1, S2 (DSP latency 2), S3 (writeback register), advancing every cycle, no stalls.
REQ-020 SHALL register writeback: wb_valid=1 in cycle k+4 with wb_rd, wb_data=dsp_out, wb_carry=dsp_carryout captured when dsp_valid_out=1.
REQ-021 SHALL assert wb_carry_en only for ADD, ADDC, SUB; wb_carry=0 otherwise.
REQ-022 SHALL deassert in_ready (combinationally) when any valid slot S0-S3 has rd equal to in_rs1_id or in_rs2_id; otherwise in_ready=1.
REQ-023 SHALL sustain one accepted op per cycle when no hazard exists.
REQ-024 SHALL, on accepted illegal funct, set illegal_err, issue nothing, occupy no slot.
REQ-025 SHALL set proto_err when dsp_valid_out differs from slot S2 valid in any cycle; writeback still follows S2 valid.
REQ-026 SHALL treat rd equal to rs1_id/rs2_id of the same op as no hazard with itself.

Reset
REQ-027 SHALL, on reset_n low, immediately clear all slot valids, dsp_*, wb_*, illegal_err, proto_err to 0.
REQ-028 SHALL discard in-flight ops on reset mid-operation; no wb_valid for them after release, and DSP results arriving after release SHALL NOT set proto_err during the first 3 cycles.
REQ-029 SHALL hold in_ready=1 out of reset (no valid slots).

Structure
REQ-030 SHALL place funct encodings, DSP opmode/alumode/setinst constants and DSP latency (2) in a shared package.
REQ-031 SHALL implement decode as sub-module alu_dsp_decode (combinational funct to controls plus legal flag).

Verification
REQ-032 AND 0x00FF,0x0F0F rd=3 accepted at k -> dsp_valid_in at k+1, wb_valid at k+4, wb_rd=3, wb_data=0x000F, wb_carry_en=0.
REQ-033 ADDC 0xFFFF,0x0001,in_carry=1 -> dsp_carryin=1, wb_data=0x0001, wb_carry=1, wb_carry_en=1.
REQ-034 ADD rd=5 at k, then op with rs1_id=5 -> in_ready low cycles k+1..k+4, accepted at k+5.
REQ-035 in_funct=0xA -> illegal_err=1, no dsp_valid_in, no wb_valid, in_ready unaffected.
REQ-036 Eight back-to-back independent ops -> eight consecutive wb_valid cycles in order; reset_n pulsed mid-stream -> no wb_valid for flushed ops, proto_err=0.

Source files
------------

// File: rtl/alu_dsp_issue_pkg.sv
// -----------------------------------------------------------------------------
// alu_dsp_issue_pkg
//   Shared definitions for the ALU-to-DSP issue block: function codes, the DSP
//   control constants (opmode / alumode / setinst), the DSP pipeline latency
//   and the decoded-control struct passed from the decoder to the issue logic.
// -----------------------------------------------------------------------------
package alu_dsp_issue_pkg;

  // Operation codes carried on in_funct. Codes 9..15 are illegal.
  typedef enum logic [3:0] {
    FUNCT_AND  = 4'd0,
    FUNCT_OR   = 4'd1,
    FUNCT_XOR  = 4'd2,
    FUNCT_ADD  = 4'd3,
    FUNCT_ADDC = 4'd4,
    FUNCT_SUB  = 4'd5,
    FUNCT_SEQ  = 4'd6,
    FUNCT_SLTU = 4'd7,
    FUNCT_SLTS = 4'd8
  } funct_e;

  // DSP opmode: OR needs the alternate Z/X routing, everything else shares one.
  localparam logic [8:0] OPMODE_OR      = 9'b000111011;
  localparam logic [8:0] OPMODE_DEFAULT = 9'b000110011;

  // DSP alumode selections.
  localparam logic [3:0] ALUMODE_LOGIC = 4'b1100;  // AND / OR
  localparam logic [3:0] ALUMODE_XOR   = 4'b0100;
  localparam logic [3:0] ALUMODE_ADD   = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB   = 4'b0011;  // SUB and all compares

  // Compare-result selection applied on top of the subtract.
  localparam logic [1:0] SETINST_NONE = 2'b00;
  localparam logic [1:0] SETINST_SEQ  = 2'b01;
  localparam logic [1:0] SETINST_SLTU = 2'b10;
  localparam logic [1:0] SETINST_SLTS = 2'b11;

  // Cycles between the DSP sampling its inputs and presenting its result.
  localparam int DSP_LATENCY = 2;

  // Tag slots: S0 issue register, DSP_LATENCY in-flight slots, writeback slot.
  localparam int NUM_SLOTS = DSP_LATENCY + 2;

  // Cycles after reset release during which DSP valid mismatches are ignored,
  // so results of flushed ops still draining from the DSP are not errors.
  localparam int PROTO_MASK_CYCLES = 3;

  typedef struct packed {
    logic [8:0] opmode;
    logic [3:0] alumode;
    logic [1:0] setinst;
    logic       carry_sel;  // forward in_carry to the DSP (ADDC)
    logic       carry_en;   // result carry is architecturally written back
  } dsp_ctrl_t;

endpackage

// File: rtl/alu_dsp_decode.sv
// -----------------------------------------------------------------------------
// alu_dsp_decode
//   Purely combinational translation of a function code into DSP controls.
//   Ports:
//     funct - operation code (4 bits)
//     ctrl  - decoded DSP controls and carry handling flags
//     legal - 1 when funct is one of the nine defined operations
// -----------------------------------------------------------------------------
module alu_dsp_decode
  import alu_dsp_issue_pkg::*;
(
  input  logic [3:0] funct,
  output dsp_ctrl_t  ctrl,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    ctrl = '{opmode:    OPMODE_DEFAULT,
             alumode:   ALUMODE_ADD,
             setinst:   SETINST_NONE,
             carry_sel: 1'b0,
             carry_en:  1'b0};
    legal = 1'b1;

    case (funct)
      FUNCT_AND:  ctrl.alumode = ALUMODE_LOGIC;
      FUNCT_OR: begin
        ctrl.opmode  = OPMODE_OR;
        ctrl.alumode = ALUMODE_LOGIC;
      end
      FUNCT_XOR:  ctrl.alumode = ALUMODE_XOR;
      FUNCT_ADD:  ctrl.carry_en = 1'b1;
      FUNCT_ADDC: begin
        ctrl.carry_sel = 1'b1;
        ctrl.carry_en  = 1'b1;
      end
      FUNCT_SUB: begin
        ctrl.alumode  = ALUMODE_SUB;
        ctrl.carry_en = 1'b1;
      end
      FUNCT_SEQ: begin
        ctrl.alumode = ALUMODE_SUB;
        ctrl.setinst = SETINST_SEQ;
      end
      FUNCT_SLTU: begin
        ctrl.alumode = ALUMODE_SUB;
        ctrl.setinst = SETINST_SLTU;
      end
      FUNCT_SLTS: begin
        ctrl.alumode = ALUMODE_SUB;
        ctrl.setinst = SETINST_SLTS;
      end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_dsp_issue.sv
// -----------------------------------------------------------------------------
// alu_dsp_issue
//   Issues ALU operations to an external DSP slice with fixed latency, tracks
//   destination tags alongside the DSP pipeline and registers the result for
//   writeback. Blocks issue on read-after-write hazards against in-flight ops.
//   Ports:
//     clock, reset_n             - clock, asynchronous active-low reset
//     in_valid/in_ready          - operation handshake
//     in_funct                   - operation code (9..15 illegal)
//     in_rs1, in_rs2, in_carry   - operand data and carry-in (ADDC)
//     in_rs1_id, in_rs2_id, in_rd- source / destination register ids
//     dsp_*  (out)               - registered DSP operands and controls
//     dsp_out, dsp_carryout,
//     dsp_valid_out (in)         - DSP result, DSP_LATENCY cycles after issue
//     wb_*                       - registered writeback
//     illegal_err, proto_err     - sticky error flags
// -----------------------------------------------------------------------------
module alu_dsp_issue
  import alu_dsp_issue_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 11
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [REG_W-1:0]  in_rs1_id,
  input  logic [REG_W-1:0]  in_rs2_id,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_carry,

  output logic [DATA_W-1:0] dsp_in0,
  output logic [DATA_W-1:0] dsp_in1,
  output logic              dsp_carryin,
  output logic [8:0]        dsp_opmode,
  output logic [3:0]        dsp_alumode,
  output logic [1:0]        dsp_setinst,
  output logic              dsp_valid_in,
  input  logic [DATA_W-1:0] dsp_out,
  input  logic              dsp_carryout,
  input  logic              dsp_valid_out,

  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_carry,
  output logic              wb_carry_en,

  output logic              illegal_err,
  output logic              proto_err
);

  // Slot whose tag lines up with the DSP result, and the writeback slot.
  localparam int S_DSP = DSP_LATENCY;
  localparam int S_WB  = DSP_LATENCY + 1;

  // ---------------------------------------------------------------------------
  // Decode and handshake
  // ---------------------------------------------------------------------------
  dsp_ctrl_t dec_ctrl;
  logic      dec_legal;

  alu_dsp_decode u_decode (
    .funct (in_funct),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_SLOTS-1:0] slot_cen_q,   slot_cen_d;
  logic [REG_W-1:0]     slot_rd_q [NUM_SLOTS];
  logic [REG_W-1:0]     slot_rd_d [NUM_SLOTS];

  logic hazard;
  logic accept;
  logic issue;

  // A source id matching any live destination tag must wait until that result
  // has been written back. The op's own rd is not in a slot yet, so an op that
  // reads and writes the same register never blocks itself.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_valid_q[i] &&
          (slot_rd_q[i] == in_rs1_id || slot_rd_q[i] == in_rs2_id)) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = ~hazard;
  assign accept   = in_valid & in_ready;
  assign issue    = accept & dec_legal;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] dsp_in0_q,     dsp_in0_d;
  logic [DATA_W-1:0] dsp_in1_q,     dsp_in1_d;
  logic              dsp_carryin_q, dsp_carryin_d;
  logic [8:0]        dsp_opmode_q,  dsp_opmode_d;
  logic [3:0]        dsp_alumode_q, dsp_alumode_d;
  logic [1:0]        dsp_setinst_q, dsp_setinst_d;

  logic [DATA_W-1:0] wb_data_q,     wb_data_d;
  logic              wb_carry_q,    wb_carry_d;

  logic              illegal_err_q, illegal_err_d;
  logic              proto_err_q,   proto_err_d;
  logic [1:0]        mask_cnt_q,    mask_cnt_d;
  logic              mask_done;

  assign mask_done = (mask_cnt_q == 2'(PROTO_MASK_CYCLES));

  always_comb begin
    // Tag pipeline: S0 loads on issue, the rest shift unconditionally.
    slot_valid_d[0] = issue;
    slot_cen_d[0]   = issue & dec_ctrl.carry_en;
    slot_rd_d[0]    = issue ? in_rd : '0;
    for (int i = 1; i < NUM_SLOTS; i++) begin
      slot_valid_d[i] = slot_valid_q[i-1];
      slot_cen_d[i]   = slot_cen_q[i-1];
      slot_rd_d[i]    = slot_rd_q[i-1];
    end

    // DSP operands are zero whenever nothing issues this cycle.
    dsp_in0_d     = issue ? in_rs1 : '0;
    dsp_in1_d     = issue ? in_rs2 : '0;
    dsp_carryin_d = issue & dec_ctrl.carry_sel & in_carry;
    dsp_opmode_d  = issue ? dec_ctrl.opmode  : '0;
    dsp_alumode_d = issue ? dec_ctrl.alumode : '0;
    dsp_setinst_d = issue ? dec_ctrl.setinst : '0;

    // Writeback is driven by our own tag, not by dsp_valid_out.
    wb_data_d  = slot_valid_q[S_DSP] ? dsp_out : '0;
    wb_carry_d = slot_valid_q[S_DSP] & slot_cen_q[S_DSP] & dsp_carryout;

    illegal_err_d = illegal_err_q | (accept & ~dec_legal);

    mask_cnt_d  = mask_done ? mask_cnt_q : mask_cnt_q + 2'd1;
    proto_err_d = proto_err_q |
                  (mask_done & (dsp_valid_out != slot_valid_q[S_DSP]));
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the tag array is a handful of flops, not a RAM, so it is reset
      // like any other register; a real memory array would not be.
      slot_valid_q <= '0;
      slot_cen_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_rd_q[i] <= '0;
      end
      dsp_in0_q     <= '0;
      dsp_in1_q     <= '0;
      dsp_carryin_q <= 1'b0;
      dsp_opmode_q  <= '0;
      dsp_alumode_q <= '0;
      dsp_setinst_q <= '0;
      wb_data_q     <= '0;
      wb_carry_q    <= 1'b0;
      illegal_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
      mask_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // and the shift pipeline moves exactly one slot per clock.
      slot_valid_q <= slot_valid_d;
      slot_cen_q   <= slot_cen_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_rd_q[i] <= slot_rd_d[i];
      end
      dsp_in0_q     <= dsp_in0_d;
      dsp_in1_q     <= dsp_in1_d;
      dsp_carryin_q <= dsp_carryin_d;
      dsp_opmode_q  <= dsp_opmode_d;
      dsp_alumode_q <= dsp_alumode_d;
      dsp_setinst_q <= dsp_setinst_d;
      wb_data_q     <= wb_data_d;
      wb_carry_q    <= wb_carry_d;
      illegal_err_q <= illegal_err_d;
      proto_err_q   <= proto_err_d;
      mask_cnt_q    <= mask_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dsp_in0      = dsp_in0_q;
  assign dsp_in1      = dsp_in1_q;
  assign dsp_carryin  = dsp_carryin_q;
  assign dsp_opmode   = dsp_opmode_q;
  assign dsp_alumode  = dsp_alumode_q;
  assign dsp_setinst  = dsp_setinst_q;
  assign dsp_valid_in = slot_valid_q[0];

  assign wb_valid    = slot_valid_q[S_WB];
  assign wb_rd       = slot_rd_q[S_WB];
  assign wb_data     = wb_data_q;
  assign wb_carry    = wb_carry_q;
  assign wb_carry_en = slot_cen_q[S_WB];

  assign illegal_err = illegal_err_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_alu_dsp_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_dsp_issue
//   Drives directed and random operations into alu_dsp_issue, emulates the DSP
//   slice with a two-stage behavioural pipeline, and compares every output each
//   cycle against a transaction-level model (queue of accepted ops with the
//   edge on which they were accepted).
// -----------------------------------------------------------------------------
module tb_alu_dsp_issue;

  localparam int DW = 16;
  localparam int RW = 11;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_funct;
  logic [DW-1:0] in_rs1, in_rs2;
  logic [RW-1:0] in_rs1_id, in_rs2_id, in_rd;
  logic          in_carry;
  logic [DW-1:0] dsp_in0, dsp_in1;
  logic          dsp_carryin;
  logic [8:0]    dsp_opmode;
  logic [3:0]    dsp_alumode;
  logic [1:0]    dsp_setinst;
  logic          dsp_valid_in;
  logic [DW-1:0] dsp_out;
  logic          dsp_carryout;
  logic          dsp_valid_out;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_carry;
  logic          wb_carry_en;
  logic          illegal_err;
  logic          proto_err;

  alu_dsp_issue #(.DATA_W(DW), .REG_W(RW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_funct      (in_funct),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rs1_id     (in_rs1_id),
    .in_rs2_id     (in_rs2_id),
    .in_rd         (in_rd),
    .in_carry      (in_carry),
    .dsp_in0       (dsp_in0),
    .dsp_in1       (dsp_in1),
    .dsp_carryin   (dsp_carryin),
    .dsp_opmode    (dsp_opmode),
    .dsp_alumode   (dsp_alumode),
    .dsp_setinst   (dsp_setinst),
    .dsp_valid_in  (dsp_valid_in),
    .dsp_out       (dsp_out),
    .dsp_carryout  (dsp_carryout),
    .dsp_valid_out (dsp_valid_out),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_carry      (wb_carry),
    .wb_carry_en   (wb_carry_en),
    .illegal_err   (illegal_err),
    .proto_err     (proto_err)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DSP slice emulation: samples its inputs on a rising edge, result two edges
  // later. Not reset, so results of flushed ops keep draining after a reset.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          c;
  } dsp_res_t;

  dsp_res_t pipe0 = '0;
  dsp_res_t pipe1 = '0;
  logic     inj   = 1'b0;  // flips dsp_valid_out to provoke a protocol error

  function automatic dsp_res_t dsp_calc(input logic v, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic ci,
                                        input logic [8:0] om, input logic [3:0] am,
                                        input logic [1:0] si);
    dsp_res_t r;
    logic [DW:0] t;
    r   = '0;
    r.v = v;
    case (am)
      4'b1100: r.d = (om == 9'b000111011) ? (a | b) : (a & b);
      4'b0100: r.d = a ^ b;
      4'b0000: begin
        t = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
        r.d = t[DW-1:0];
        r.c = t[DW];
      end
      4'b0011: begin
        t = {1'b0, a} - {1'b0, b};
        r.d = t[DW-1:0];
        r.c = ~t[DW];
        case (si)
          2'b01:   r.d = {{(DW-1){1'b0}}, a == b};
          2'b10:   r.d = {{(DW-1){1'b0}}, a < b};
          2'b11:   r.d = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
          default: ;
        endcase
      end
      default: r.d = '0;
    endcase
    return r;
  endfunction

  always @(posedge clock) begin
    pipe0 <= dsp_calc(dsp_valid_in, dsp_in0, dsp_in1, dsp_carryin,
                      dsp_opmode, dsp_alumode, dsp_setinst);
    pipe1 <= pipe0;
  end

  assign dsp_out       = pipe1.d;
  assign dsp_carryout  = pipe1.c;
  assign dsp_valid_out = pipe1.v ^ inj;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int            acc_edge;
    logic [3:0]    f;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [RW-1:0] rd;
  } op_t;

  op_t  q[$];
  int   edge_cnt    = 0;
  logic exp_illegal = 1'b0;
  logic exp_proto   = 1'b0;
  int   n_tests     = 0;
  int   n_fail      = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp,
               edge_cnt);
    end
  endtask

  // Architectural result of an operation, straight from the op definitions.
  task automatic ref_result(input op_t o, output logic [DW-1:0] d,
                            output logic c, output logic cen);
    logic [DW:0] s;
    c   = 1'b0;
    cen = 1'b0;
    d   = '0;
    case (o.f)
      4'd0: d = o.a & o.b;
      4'd1: d = o.a | o.b;
      4'd2: d = o.a ^ o.b;
      4'd3, 4'd4: begin
        s = o.a + o.b + ((o.f == 4'd4) ? o.cin : 1'b0);
        d = s[DW-1:0];
        c = s[DW];
        cen = 1'b1;
      end
      4'd5: begin
        d = o.a - o.b;
        c = (o.a >= o.b);
        cen = 1'b1;
      end
      4'd6: d = DW'(o.a == o.b);
      4'd7: d = DW'(o.a < o.b);
      4'd8: d = DW'($signed(o.a) < $signed(o.b));
      default: ;
    endcase
  endtask

  // DSP control table per operation.
  task automatic ref_ctrl(input logic [3:0] f, output logic [8:0] om,
                          output logic [3:0] am, output logic [1:0] si);
    om = (f == 4'd1) ? 9'b000111011 : 9'b000110011;
    si = (f == 4'd6) ? 2'b01 : (f == 4'd7) ? 2'b10 : (f == 4'd8) ? 2'b11 : 2'b00;
    case (f)
      4'd0, 4'd1: am = 4'b1100;
      4'd2:       am = 4'b0100;
      4'd3, 4'd4: am = 4'b0000;
      default:    am = 4'b0011;
    endcase
  endtask

  // An op accepted on edge k blocks readers of its rd through the cycle that
  // follows edge k+3 (the writeback cycle).
  function automatic logic ref_ready(input logic [RW-1:0] id1,
                                     input logic [RW-1:0] id2);
    foreach (q[i]) begin
      if (edge_cnt - q[i].acc_edge <= 3 && (q[i].rd == id1 || q[i].rd == id2))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  // Called mid-cycle, after edge edge_cnt.
  task automatic check_outputs();
    logic          iss_hit, wb_hit;
    op_t           iss_op, wb_op;
    logic [DW-1:0] d;
    logic          c, cen;
    logic [8:0]    om;
    logic [3:0]    am;
    logic [1:0]    si;
    while (q.size() > 0 && edge_cnt - q[0].acc_edge > 3) void'(q.pop_front());
    iss_hit = 1'b0;
    wb_hit  = 1'b0;
    foreach (q[i]) begin
      if (q[i].acc_edge == edge_cnt)     begin iss_hit = 1'b1; iss_op = q[i]; end
      if (q[i].acc_edge == edge_cnt - 3) begin wb_hit  = 1'b1; wb_op  = q[i]; end
    end
    check("dsp_valid_in", dsp_valid_in, iss_hit);
    if (iss_hit) begin
      ref_ctrl(iss_op.f, om, am, si);
      check("dsp_in0", dsp_in0, iss_op.a);
      check("dsp_in1", dsp_in1, iss_op.b);
      check("dsp_carryin", dsp_carryin, (iss_op.f == 4'd4) & iss_op.cin);
      check("dsp_opmode", dsp_opmode, om);
      check("dsp_alumode", dsp_alumode, am);
      check("dsp_setinst", dsp_setinst, si);
    end else begin
      check("dsp_idle", {dsp_in0, dsp_in1, dsp_carryin, dsp_opmode,
                         dsp_alumode, dsp_setinst}, '0);
    end
    check("wb_valid", wb_valid, wb_hit);
    if (wb_hit) begin
      ref_result(wb_op, d, c, cen);
      check("wb_rd", wb_rd, wb_op.rd);
      check("wb_data", wb_data, d);
      check("wb_carry", wb_carry, c);
      check("wb_carry_en", wb_carry_en, cen);
    end
    check("illegal_err", illegal_err, exp_illegal);
    check("proto_err", proto_err, exp_proto);
  endtask

  // One clock of stimulus. Entered between edges; returns mid-cycle after the
  // next edge with outputs checked. got_ready is what the DUT presented.
  task automatic step(input logic v, input logic [3:0] f,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] id1, input logic [RW-1:0] id2,
                      input logic [RW-1:0] rd, input logic cin,
                      output logic got_ready);
    logic exp_rdy;
    op_t  o;
    in_valid  = v;
    in_funct  = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rs1_id = id1;
    in_rs2_id = id2;
    in_rd     = rd;
    in_carry  = cin;
    #1;
    exp_rdy   = ref_ready(id1, id2);
    got_ready = in_ready;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clock);
    edge_cnt++;
    if (inj) exp_proto = 1'b1;
    if (v && exp_rdy) begin
      if (f <= 4'd8) begin
        o = '{acc_edge: edge_cnt, f: f, a: a, b: b, cin: cin, rd: rd};
        q.push_back(o);
      end else begin
        exp_illegal = 1'b1;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, '0, 11'd2047, 11'd2047, '0, 1'b0, r);
  endtask

  // Reset pulse entirely between two rising edges; outputs must clear at once.
  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_dsp_valid_in", dsp_valid_in, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_errs", {illegal_err, proto_err}, 2'b00);
    #1 reset_n = 1'b1;
    q.delete();
    exp_illegal = 1'b0;
    exp_proto   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic r;
    int   stalls;
    in_valid = 1'b0; in_funct = '0; in_rs1 = '0; in_rs2 = '0;
    in_rs1_id = '0; in_rs2_id = '0; in_rd = '0; in_carry = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready", in_ready, 1'b1);
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_dsp_valid_in", dsp_valid_in, 1'b0);
    check("reset_errs", {illegal_err, proto_err}, 2'b00);
    #2 reset_n = 1'b1;
    @(negedge clock);
    idle(4);

    // AND 0x00FF & 0x0F0F -> 0x000F into r3, no carry enable.
    step(1'b1, 4'd0, 16'h00FF, 16'h0F0F, 11'd1, 11'd2, 11'd3, 1'b0, r);
    idle(4);
    check("and_wb_data", wb_data, 16'h0000);  // writeback slot has drained
    // ADDC 0xFFFF + 0x0001 + 1 -> 0x0001, carry out.
    step(1'b1, 4'd4, 16'hFFFF, 16'h0001, 11'd1, 11'd2, 11'd4, 1'b1, r);
    idle(4);

    // RAW hazard: ADD writes r5, reader of r5 stalls for four cycles.
    step(1'b1, 4'd3, 16'h1234, 16'h1111, 11'd1, 11'd2, 11'd5, 1'b0, r);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd1, 16'h0F00, 16'h00F0, 11'd5, 11'd6, 11'd9, 1'b0, r);
      if (r) break;
      stalls++;
    end
    check("hazard_stall_cycles", stalls, 4);
    idle(4);

    // Reading and writing the same register is not a hazard with itself.
    step(1'b1, 4'd5, 16'h0003, 16'h0007, 11'd20, 11'd21, 11'd20, 1'b0, r);
    check("self_dep_ready", r, 1'b1);
    idle(4);

    // Illegal funct: flagged, nothing issued.
    step(1'b1, 4'hA, 16'h5555, 16'hAAAA, 11'd30, 11'd31, 11'd32, 1'b0, r);
    check("illegal_ready", r, 1'b1);
    idle(4);

    // Eight back-to-back independent ops, all compare/arith flavours.
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'(i + 1), 16'($urandom), 16'($urandom), 11'(i), 11'(i + 1),
           11'(100 + i), 1'($urandom), r);
    idle(5);

    // Random traffic with a small register file so hazards are frequent.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15))
                                        : 4'($urandom_range(0, 8)),
           ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
           11'($urandom_range(0, 7)), 11'($urandom_range(0, 7)),
           11'($urandom_range(0, 7)), 1'($urandom), r);
    idle(5);

    // Reset pulsed mid-stream: in-flight ops vanish, draining DSP results
    // must not raise proto_err.
    for (int i = 0; i < 6; i++)
      step(1'b1, 4'(i), 16'($urandom), 16'($urandom), 11'(200 + i), 11'(300 + i),
           11'(400 + i), 1'b0, r);
    pulse_reset();
    idle(8);
    check("post_reset_proto", proto_err, 1'b0);

    // Forced DSP valid mismatch after the mask window sets proto_err.
    inj = 1'b1;
    idle(1);
    inj = 1'b0;
    idle(2);
    pulse_reset();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
